// File: rtl/ah_pkt_conv_pkg.sv
// Shared helpers for the wide/narrow packet converters: sizing functions and lane slicing.
package ah_pkt_conv_pkg;

  localparam int PAD_MAX = 256;
  localparam int NW_MAX  = 64;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction

  function automatic int lanes_of(input int wide_w, input int narrow_w);
    return (wide_w + narrow_w - 1) / narrow_w;
  endfunction

  // Lane 0 is the most significant narrow slice of the left-aligned padded vector.
  function automatic logic [NW_MAX-1:0] lane_extract(input logic [PAD_MAX-1:0] padded,
                                                     input int lanes, input int narrow_w,
                                                     input int idx);
    logic [PAD_MAX-1:0] s;
    s = padded >> ((lanes - 1 - idx) * narrow_w);
    return s[NW_MAX-1:0] & ((NW_MAX'(1) << narrow_w) - 1'b1);
  endfunction

endpackage

// File: rtl/ah_pkt_fifo.sv
// Small synchronous FIFO with head read; push when full and pop when empty are ignored.
module ah_pkt_fifo
  import ah_pkt_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ah_packet_converter_w2n.sv
// Wide-to-narrow converter: buffers wide packets and serialises each into LANES narrow
// beats, MSB lane first, under upstream and downstream credit flow control.
module ah_packet_converter_w2n
  import ah_pkt_conv_pkg::*;
#(
  parameter int WIDE_W      = 15,
  parameter int NARROW_W    = 10,
  parameter int IN_DEPTH    = 2,
  parameter int OUT_CREDITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [WIDE_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rcredit,
  output logic [NARROW_W-1:0] wdata,
  output logic                wvalid,
  input  logic                wcredit,
  output logic                err_overflow,
  output logic                err_credit
);
  localparam int LANES = lanes_of(WIDE_W, NARROW_W);
  localparam int PAD_W = LANES * NARROW_W;
  localparam int LW    = (LANES > 1) ? clog2(LANES) : 1;
  localparam int CW    = clog2(OUT_CREDITS + 1);

  logic [WIDE_W-1:0]   head;
  logic                full, empty, send, last, push, pop;
  logic [LW-1:0]       lane;
  logic [CW-1:0]       credit;
  logic [PAD_MAX-1:0]  padded;
  logic [NARROW_W-1:0] beat;

  assign padded = PAD_MAX'(head) << (PAD_W - WIDE_W);
  assign beat   = NARROW_W'(lane_extract(padded, LANES, NARROW_W, int'(lane)));
  assign send   = ~empty & (credit != '0);
  assign last   = (lane == LW'(LANES - 1));
  // A full FIFO drops the packet even if a pop frees a slot this same cycle.
  assign push   = rvalid & ~full;
  assign pop    = send & last;

  ah_pkt_fifo #(.WIDTH(WIDE_W), .DEPTH(IN_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (rdata),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane         <= '0;
      credit       <= CW'(OUT_CREDITS);
      wdata        <= '0;
      wvalid       <= 1'b0;
      rcredit      <= 1'b0;
      err_overflow <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      wvalid  <= send;
      rcredit <= pop;
      if (send) begin
        wdata <= beat;
        lane  <= last ? '0 : lane + 1'b1;
      end
      if (rvalid && full) err_overflow <= 1'b1;
      case ({send, wcredit})
        2'b10: credit <= credit - 1'b1;
        2'b01: begin
          if (credit == CW'(OUT_CREDITS)) err_credit <= 1'b1;
          else                            credit     <= credit + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ah_packet_converter_w2n.sv
// Directed and randomized bench for ah_packet_converter_w2n against a beat-queue reference model.
module tb_ah_packet_converter_w2n;
  localparam int WW = 15, NW = 10, ID = 2, OC = 4, LN = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [WW-1:0] rdata = '0;
  logic          rvalid = 1'b0, wcredit = 1'b0;
  logic          rcredit, wvalid, err_overflow, err_credit;
  logic [NW-1:0] wdata;

  always #5 clk = ~clk;

  ah_packet_converter_w2n #(.WIDE_W(WW), .NARROW_W(NW), .IN_DEPTH(ID), .OUT_CREDITS(OC)) dut (
    .clk(clk), .rstn(rstn), .rdata(rdata), .rvalid(rvalid), .rcredit(rcredit),
    .wdata(wdata), .wvalid(wvalid), .wcredit(wcredit),
    .err_overflow(err_overflow), .err_credit(err_credit)
  );

  int checks = 0, errors = 0, beats = 0, run = 0, max_run = 0, rc_pulses = 0;
  string phase = "reset";

  // Reference: pending narrow beats of accepted packets, packets held, downstream credits.
  logic [NW-1:0] bq_d[$];
  bit            bq_l[$];
  int            occ, cred;
  bit            m_wv, m_rc, m_eo, m_ec;
  logic [NW-1:0] m_wd;

  function automatic logic [NW-1:0] lane_of(input logic [WW-1:0] p, input int i);
    longint unsigned pad;
    pad = longint'(p) << (LN * NW - WW);
    return NW'((pad >> ((LN - 1 - i) * NW)) & ((64'd1 << NW) - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bq_d.delete(); bq_l.delete();
    occ = 0; cred = OC;
    m_wv = 0; m_rc = 0; m_eo = 0; m_ec = 0; m_wd = '0;
  endtask

  task automatic check_all();
    chk({phase, ".wvalid"},  32'(wvalid),       32'(m_wv));
    chk({phase, ".wdata"},   32'(wdata),        32'(m_wd));
    chk({phase, ".rcredit"}, 32'(rcredit),      32'(m_rc));
    chk({phase, ".err_ovf"}, 32'(err_overflow), 32'(m_eo));
    chk({phase, ".err_crd"}, 32'(err_credit),   32'(m_ec));
  endtask

  task automatic step(input bit rv, input logic [WW-1:0] rd, input bit wc);
    bit send, full;
    @(negedge clk);
    rvalid = rv; rdata = rd; wcredit = wc;
    @(posedge clk);
    send = (bq_d.size() > 0) && (cred > 0);
    full = (occ == ID);
    m_wv = send; m_rc = 0;
    if (send) begin
      m_wd = bq_d.pop_front();
      m_rc = bq_l.pop_front();
      if (m_rc) occ--;
    end
    if (rv) begin
      if (full) m_eo = 1;
      else begin
        for (int i = 0; i < LN; i++) begin
          bq_d.push_back(lane_of(rd, i));
          bq_l.push_back(i == LN - 1);
        end
        occ++;
      end
    end
    if (wc && !send) begin
      if (cred == OC) m_ec = 1; else cred++;
    end else if (send && !wc) cred--;
    #1;
    check_all();
    if (wvalid === 1'b1) begin beats++; run++; end else run = 0;
    if (run > max_run) max_run = run;
    if (rcredit === 1'b1) rc_pulses++;
  endtask

  task automatic idle(input int n, input bit ret);
    for (int i = 0; i < n; i++) step(1'b0, '0, ret && (cred < OC));
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    @(negedge clk) rstn = 1'b1;
    phase = "idle";
    idle(3, 1'b0);

    phase = "single";
    step(1'b1, 15'h5A5A, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("single.lane0", {wvalid, 21'd0, wdata}, {1'b1, 21'd0, 10'h2D2});
    step(1'b0, '0, 1'b0);
    chk("single.lane1", {wvalid, rcredit, 20'd0, wdata}, {1'b1, 1'b1, 20'd0, 10'h340});
    step(1'b0, '0, 1'b0);
    chk("single.rc_once", 32'(rcredit), 32'd0);
    idle(4, 1'b1);

    phase = "stall";
    beats = 0;
    step(1'b1, 15'h1234, 1'b0);
    step(1'b1, 15'h7FFF, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 15'h0001, 1'b0);
    idle(6, 1'b0);
    chk("stall.beats4", 32'(beats), 32'd4);
    step(1'b0, '0, 1'b1);
    idle(4, 1'b0);
    chk("stall.beats5", 32'(beats), 32'd5);
    idle(12, 1'b1);

    phase = "b2b";
    max_run = 0; rc_pulses = 0; run = 0;
    step(1'b1, 15'h2AAA, cred < OC);
    step(1'b1, 15'h5555, cred < OC);
    idle(8, 1'b1);
    chk("b2b.run4", 32'(max_run), 32'd4);
    chk("b2b.rc2", 32'(rc_pulses), 32'd2);

    phase = "ovf";
    step(1'b1, 15'h0F0F, 1'b0);
    step(1'b1, 15'h7070, 1'b0);
    idle(5, 1'b0);
    step(1'b1, 15'h1111, 1'b0);
    step(1'b1, 15'h2222, 1'b0);
    step(1'b1, 15'h3333, 1'b0);
    chk("ovf.flag", 32'(err_overflow), 32'd1);
    beats = 0;
    idle(16, 1'b1);
    chk("ovf.drop3rd", 32'(beats), 32'd4);
    step(1'b0, '0, 1'b1);
    chk("ovf.err_credit", 32'(err_credit), 32'd1);
    step(1'b1, 15'h4444, 1'b0);
    step(1'b0, '0, 1'b0);
    idle(6, 1'b0);

    phase = "midrst";
    @(negedge clk) rstn = 1'b0;
    model_reset();
    @(negedge clk) rstn = 1'b1;
    step(1'b1, 15'h6B6B, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("midrst.lane0", 32'(wvalid), 32'd1);
    @(negedge clk) rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk) rstn = 1'b1;
    beats = 0;
    idle(3, 1'b0);
    chk("midrst.nolane1", 32'(beats), 32'd0);
    step(1'b1, 15'h3C3C, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("midrst.new0", 32'(wdata), 32'(lane_of(15'h3C3C, 0)));
    step(1'b0, '0, 1'b0);
    chk("midrst.new1", 32'(wdata), 32'(lane_of(15'h3C3C, 1)));
    idle(3, 1'b1);

    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      bit wc;
      wc = (cred < OC) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      step(bit'($urandom_range(0, 1)), WW'($urandom), wc);
    end
    idle(20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
